// File: rtl/viterbi_frame_ctrl_if.sv
// Handshake and status bundle between the frame sequencer and its environment.
// master: side that issues start/config and returns the decoded bit (bench/host).
// slave : the frame sequencer itself.
//   start, err_en, err_mask_cfg : frame launch and injection configuration
//   decoder_o                   : decoded bit coming back from the decoder
//   encoder_i, enable_encoder_i : bit stream and enable toward the encoder
//   err_inj                     : XOR mask for the channel register
//   busy, done                  : frame activity and end-of-frame pulse
//   bit_err_ct, inj_ct, frame_ct: per-frame and global counters
interface viterbi_frame_ctrl_if;
  logic        start;
  logic        err_en;
  logic [1:0]  err_mask_cfg;
  logic        decoder_o;
  logic        encoder_i;
  logic        enable_encoder_i;
  logic [1:0]  err_inj;
  logic        busy;
  logic        done;
  logic [15:0] bit_err_ct;
  logic [15:0] inj_ct;
  logic [15:0] frame_ct;

  modport master (
    output start, err_en, err_mask_cfg, decoder_o,
    input  encoder_i, enable_encoder_i, err_inj, busy, done,
           bit_err_ct, inj_ct, frame_ct
  );

  modport slave (
    input  start, err_en, err_mask_cfg, decoder_o,
    output encoder_i, enable_encoder_i, err_inj, busy, done,
           bit_err_ct, inj_ct, frame_ct
  );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the encoder / channel / Viterbi loopback.
// Sends FRAME_LEN LFSR message bits plus TAIL zero flush bits to the encoder,
// schedules periodic error-injection masks, and compares the decoder output
// against a DEC_LAT-delayed copy of the message to count bit errors.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : viterbi_frame_ctrl_if.slave (start/config in, stream and counters out)
module viterbi_frame_ctrl #(
  parameter int          FRAME_LEN  = 64,
  parameter int          TAIL       = 2,
  parameter int          DEC_LAT    = 40,
  parameter int          ERR_PERIOD = 16,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input logic                 clk,
  input logic                 rst,
  viterbi_frame_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int          CW        = 13;
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CW-1:0] MSG_LAST  = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(FRAME_LEN + TAIL - 1);
  localparam logic [CW-1:0] FRAME_CMP = CW'(FRAME_LEN);
  localparam logic [CW-1:0] EP_MASK   = CW'(ERR_PERIOD - 1);

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [2:0]         state;
  logic [15:0]        lfsr;
  logic [CW-1:0]      wcnt_p0;
  logic [CW-1:0]      cmp_ct;
  logic [CW-1:0]      cmp_nxt;
  logic               err_en_q;
  logic [1:0]         mask_q;
  logic               enc_p1;
  logic               en_p1;
  logic               vld_p1;
  logic               inj_p1;
  logic [1:0]         err_inj_p2;
  logic               busy_p1;
  logic               done_p1;
  logic [15:0]        bit_err_ct;
  logic [15:0]        inj_ct;
  logic [15:0]        frame_ct;
  logic [DEC_LAT-1:0] dl_bit;
  logic [DEC_LAT-1:0] dl_vld;
  logic               sending;

  assign sending = (state == S_SEND) || (state == S_FLUSH);
  assign cmp_nxt = cmp_ct + CW'(dl_vld[DEC_LAT-1]);

  // Stage p0 -> p1: state-domain decisions become registered outputs one cycle later.
  // Stage p1 -> p2: injection mask lags the encoder bit to match its output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lfsr       <= SEED_EFF;
      wcnt_p0    <= '0;
      cmp_ct     <= '0;
      err_en_q   <= 1'b0;
      mask_q     <= 2'b00;
      enc_p1     <= 1'b0;
      en_p1      <= 1'b0;
      vld_p1     <= 1'b0;
      inj_p1     <= 1'b0;
      err_inj_p2 <= 2'b00;
      busy_p1    <= 1'b0;
      done_p1    <= 1'b0;
      bit_err_ct <= '0;
      inj_ct     <= '0;
      frame_ct   <= '0;
      dl_vld     <= '0;
    end else begin
      busy_p1    <= (state != S_IDLE);
      done_p1    <= (state == S_DONE);
      en_p1      <= sending;
      enc_p1     <= (state == S_SEND) & lfsr[0];
      vld_p1     <= (state == S_SEND);
      inj_p1     <= sending && err_en_q && (mask_q != 2'b00) &&
                    ((wcnt_p0 & EP_MASK) == '0);
      err_inj_p2 <= inj_p1 ? mask_q : 2'b00;
      if (inj_p1) inj_ct <= inj_ct + 16'd1;
      if (state == S_DONE) frame_ct <= frame_ct + 16'd1;

      dl_vld[0] <= vld_p1;
      for (int k = 1; k < DEC_LAT; k++) dl_vld[k] <= dl_vld[k-1];

      if (dl_vld[DEC_LAT-1]) begin
        cmp_ct <= cmp_nxt;
        if (bus.decoder_o != dl_bit[DEC_LAT-1]) bit_err_ct <= sat_inc16(bit_err_ct);
      end

      // Placed last so the frame-start clears take precedence.
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            err_en_q   <= bus.err_en;
            mask_q     <= bus.err_mask_cfg;
            bit_err_ct <= '0;
            inj_ct     <= '0;
            wcnt_p0    <= '0;
            cmp_ct     <= '0;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          lfsr    <= lfsr_next(lfsr);
          wcnt_p0 <= wcnt_p0 + 1'b1;
          if (wcnt_p0 == MSG_LAST) state <= (TAIL == 0) ? S_DRAIN : S_FLUSH;
        end
        S_FLUSH: begin
          wcnt_p0 <= wcnt_p0 + 1'b1;
          if (wcnt_p0 == WORD_LAST) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Look ahead one compare so done lands right after the last count update.
          if (cmp_nxt >= FRAME_CMP) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data-only delay line; the valid flags above carry the control meaning.
  always_ff @(posedge clk) begin
    dl_bit[0] <= enc_p1;
    for (int k = 1; k < DEC_LAT; k++) dl_bit[k] <= dl_bit[k-1];
  end

  assign bus.encoder_i        = enc_p1;
  assign bus.enable_encoder_i = en_p1;
  assign bus.err_inj          = err_inj_p2;
  assign bus.busy             = busy_p1;
  assign bus.done             = done_p1;
  assign bus.bit_err_ct       = bit_err_ct;
  assign bus.inj_ct           = inj_ct;
  assign bus.frame_ct         = frame_ct;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl: directed scenarios plus randomized frames,
// checked every cycle against a frame-relative behavioural model.
module tb_viterbi_frame_ctrl;
  localparam int FL = 64;
  localparam int TL = 2;
  localparam int DL = 40;
  localparam int EP = 16;
  localparam int L  = FL + DL + 2;   // start edge to done cycle

  logic clk = 1'b0;
  logic rst;
  viterbi_frame_ctrl_if bus();

  viterbi_frame_ctrl #(
    .FRAME_LEN(FL), .TAIL(TL), .DEC_LAT(DL), .ERR_PERIOD(EP), .SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int e = -1;              // index of the most recent rising edge
  int fs = -1;             // edge that launched the current frame, -1 = none
  bit [15:0] lfsr_m;
  bit msg[FL];
  bit flip_cur[FL];
  bit flip_nxt[FL];
  bit en_l;
  bit [1:0] mask_l;
  bit cfg_en;
  bit [1:0] cfg_mask;
  int exp_be;
  int exp_inj;
  int fct_m;
  bit enc_hist[8192];
  bit flip_hist[8192];
  bit cap[4];
  int done_seen[$];
  int inj_r[$];

  function automatic bit [15:0] lfsr_step(input bit [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, e, act, exp_v);
    end
  endtask

  // Drive inputs for the next edge, advance one cycle, update model, check outputs.
  task automatic tick(input bit st, input bit rs);
    int  c;
    int  r;
    bit  launch;
    bit  x_busy, x_en, x_enc, x_done;
    bit [1:0] x_inj;
    c = e - DL;
    bus.decoder_o    = (c >= 0) ? (enc_hist[c] ^ flip_hist[c]) : 1'b0;
    bus.start        = st;
    bus.err_en       = cfg_en;
    bus.err_mask_cfg = cfg_mask;
    rst              = rs;
    launch = !rs && st && (fs < 0 || e >= fs + L);
    @(posedge clk);
    e++;
    if (rs) begin
      fs = -1; lfsr_m = 16'hACE1; fct_m = 0; exp_be = 0; exp_inj = 0;
    end else if (launch) begin
      fs = e; en_l = cfg_en; mask_l = cfg_mask; exp_be = 0; exp_inj = 0;
      for (int i = 0; i < FL; i++) begin
        msg[i] = lfsr_m[0];
        lfsr_m = lfsr_step(lfsr_m);
        flip_cur[i] = flip_nxt[i];
        exp_be += int'(flip_nxt[i]);
      end
      if (en_l && mask_l != 2'b00)
        for (int w = 0; w < FL + TL; w++) if (w % EP == 0) exp_inj++;
    end
    if (fs >= 0 && e == fs + L) fct_m = (fct_m + 1) & 16'hFFFF;
    @(negedge clk);
    r = (fs >= 0) ? e - fs : -1;
    x_busy = (r >= 1 && r <= L);
    x_en   = (r >= 1 && r <= FL + TL);
    x_enc  = (r >= 1 && r <= FL) ? msg[r-1] : 1'b0;
    x_done = (r == L);
    x_inj  = (en_l && mask_l != 2'b00 && r >= 2 && r <= FL + TL + 1 && (r - 2) % EP == 0)
             ? mask_l : 2'b00;
    enc_hist[e]  = x_enc;
    flip_hist[e] = (r >= 1 && r <= FL) ? flip_cur[r-1] : 1'b0;
    chk("busy", 32'(bus.busy), 32'(x_busy));
    chk("done", 32'(bus.done), 32'(x_done));
    chk("enable_encoder_i", 32'(bus.enable_encoder_i), 32'(x_en));
    chk("encoder_i", 32'(bus.encoder_i), 32'(x_enc));
    chk("err_inj", 32'(bus.err_inj), 32'(x_inj));
    chk("frame_ct", 32'(bus.frame_ct), 32'(fct_m));
    if (fs < 0 || r == 0 || r >= L) begin
      chk("bit_err_ct", 32'(bus.bit_err_ct), (fs < 0 || r == 0) ? 32'd0 : 32'(exp_be));
      chk("inj_ct", 32'(bus.inj_ct), (fs < 0 || r == 0) ? 32'd0 : 32'(exp_inj));
    end
    if (r >= 1 && r <= 4) cap[r-1] = bus.encoder_i;
    if (bus.done === 1'b1) done_seen.push_back(e);
    if (fs >= 0 && bus.err_inj != 2'b00) inj_r.push_back(r);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  task automatic chk_first_bits(input string tag);
    chk({tag, "_bit0"}, 32'(cap[0]), 32'd1);
    chk({tag, "_bit1"}, 32'(cap[1]), 32'd0);
    chk({tag, "_bit2"}, 32'(cap[2]), 32'd0);
    chk({tag, "_bit3"}, 32'(cap[3]), 32'd0);
  endtask

  int f0;
  int fc_before;
  int inj_exp_r[5] = '{2, 18, 34, 50, 66};

  initial begin
    for (int i = 0; i < FL; i++) flip_nxt[i] = 1'b0;
    cfg_en = 1'b0; cfg_mask = 2'b00;
    lfsr_m = 16'hACE1; en_l = 1'b0; mask_l = 2'b00;
    bus.start = 1'b0; bus.err_en = 1'b0; bus.err_mask_cfg = 2'b00; bus.decoder_o = 1'b0;
    rst = 1'b1;
    repeat (3) tick(1'b0, 1'b1);
    idle(2);

    // Ideal decoder, no injection.
    done_seen.delete();
    tick(1'b1, 1'b0); f0 = e;
    idle(L + 2);
    chk_first_bits("ideal");
    chk("ideal_done_count", done_seen.size(), 1);
    if (done_seen.size() > 0) chk("ideal_done_cycle", done_seen[0] - f0, 106);
    chk("ideal_frame_ct", 32'(bus.frame_ct), 1);
    chk("ideal_bit_err", 32'(bus.bit_err_ct), 0);

    // Decoder inverts message bit 10.
    flip_nxt[10] = 1'b1;
    tick(1'b1, 1'b0);
    flip_nxt[10] = 1'b0;
    idle(L + 2);
    chk("flip_bit_err", 32'(bus.bit_err_ct), 1);
    chk("flip_inj_ct", 32'(bus.inj_ct), 0);

    // Injection with mask 11, then mask 00.
    cfg_en = 1'b1; cfg_mask = 2'b11; inj_r.delete();
    tick(1'b1, 1'b0);
    idle(L + 2);
    chk("inj_count", inj_r.size(), 5);
    for (int i = 0; i < 5 && i < inj_r.size(); i++) chk("inj_cycle", inj_r[i], inj_exp_r[i]);
    chk("inj_ct_mask3", 32'(bus.inj_ct), 5);
    cfg_mask = 2'b00; inj_r.delete();
    tick(1'b1, 1'b0);
    idle(L + 2);
    chk("inj_ct_mask0", 32'(bus.inj_ct), 0);
    chk("inj_mask0_none", inj_r.size(), 0);
    cfg_en = 1'b0;

    // Second start while busy is ignored.
    done_seen.delete(); fc_before = int'(bus.frame_ct);
    tick(1'b1, 1'b0); f0 = e;
    idle(29);
    tick(1'b1, 1'b0);
    idle(L + 2 - 30);
    chk("busy_start_dones", done_seen.size(), 1);
    if (done_seen.size() > 0) chk("busy_start_done_cycle", done_seen[0] - f0, 106);
    chk("busy_start_frames", int'(bus.frame_ct) - fc_before, 1);

    // Reset at cycle 20 aborts; new frame replays from SEED.
    done_seen.delete();
    tick(1'b1, 1'b0);
    idle(19);
    tick(1'b0, 1'b1);
    chk("abort_frame_ct", 32'(bus.frame_ct), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    idle(1);
    tick(1'b1, 1'b0);
    idle(L + 2);
    chk_first_bits("replay");
    chk("abort_dones", done_seen.size(), 1);

    // start held high for three frames, from a fresh reset.
    tick(1'b0, 1'b1);
    idle(1);
    done_seen.delete();
    repeat (3 * (L + 1)) tick(1'b1, 1'b0);
    idle(3);
    chk("held_dones", done_seen.size(), 3);
    if (done_seen.size() == 3) begin
      chk("held_gap1", done_seen[1] - done_seen[0], 107);
      chk("held_gap2", done_seen[2] - done_seen[1], 107);
    end
    chk("held_frame_ct", 32'(bus.frame_ct), 3);

    // Randomized frames with stray starts during busy.
    repeat (8) begin
      cfg_en   = 1'($urandom_range(0, 1));
      cfg_mask = 2'($urandom_range(0, 3));
      for (int i = 0; i < FL; i++) flip_nxt[i] = ($urandom_range(0, 7) == 0);
      idle($urandom_range(0, 5));
      tick(1'b1, 1'b0);
      for (int i = 0; i < FL; i++) flip_nxt[i] = 1'b0;
      repeat (L) tick(($urandom_range(0, 7) == 0), 1'b0);
      idle(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame sequencer for the convolutional-encoder / channel / Viterbi-decoder loopback. It generates a pseudo-random message frame into the encoder and appends flush (tail) bits. It schedules periodic error-injection masks for the channel register, then compares decoder output against a delayed copy of the transmitted bits and reports per-frame bit-error and injection counts. It replaces free-running testbench stimulus with one deterministic, restartable frame engine.

## Interface
- FRAME_LEN, 64: message bits per frame (1..4095)
- TAIL, 2: zero flush bits after the message (K-1)
- DEC_LAT, 40: cycles from a bit on encoder_i to its decoded bit on decoder_o (TAIL ≤ DEC_LAT ≤ 63)
- ERR_PERIOD, 16: injection period in encoder words (power of 2, ≥2)
- SEED, 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- err_en  in  1  enable error injection for the frame (latched at start)
- err_mask_cfg  in  2  XOR pattern to inject (latched at start)
- decoder_o  in  1  decoded bit from the decoder
- encoder_i  out  1  bit to the encoder
- enable_encoder_i  out  1  encoder enable
- err_inj  out  2  XOR mask for the channel register
- busy  out  1  high from SEND through DONE
- done  out  1  one-cycle pulse at frame end
- bit_err_ct  out  16  message-bit mismatches this frame, saturating
- inj_ct  out  16  non-zero injections this frame
- frame_ct  out  16  completed frames since reset, wraps

## Operation
- All outputs are registered. After rst, every output is 0 and the LFSR is loaded with SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. encoder_i = lfsr[0] in SEND. The LFSR advances once per SEND cycle. It is not reloaded between frames; only rst reloads it.
- IDLE: all strobes low. On start, the block latches err_en and err_mask_cfg, clears bit_err_ct and inj_ct, zeros the word counter and compare counter, and moves to SEND.
- SEND, FRAME_LEN cycles: enable_encoder_i=1, encoder_i=LFSR bit. Each bit is pushed into a DEC_LAT-deep delay line together with a valid flag of 1. The state then moves to FLUSH.
- FLUSH, TAIL cycles: enable_encoder_i=1, encoder_i=0. Each tail bit is pushed with valid=0. The state then moves to DRAIN.
- DRAIN: enable_encoder_i=0, and 0/invalid is pushed into the delay line. When the compare counter reaches FRAME_LEN, the state moves to DONE.
- DONE, 1 cycle: done=1, frame_ct increments, busy is still 1. The state then moves to IDLE.
- Compare:
  - Each cycle the delay-line output valid flag is 1, the block increments the compare counter.
  - If decoder_o differs from the delayed bit, it also increments bit_err_ct, saturating at 16'hFFFF.
  - Tail bits are never compared.
- Injection:
  - Word index w counts enable cycles from 0 (message words 0..FRAME_LEN-1, tail words after).
  - If the latched err_en=1, w mod ERR_PERIOD==0, and the latched mask ≠ 0, then err_inj = mask and inj_ct increments. Otherwise err_inj = 0.
  - err_inj is 0 in IDLE, DRAIN and DONE.
- start asserted while busy is ignored, with no queuing. start held high launches a new frame on the first IDLE cycle.
- rst mid-frame aborts immediately. No done pulse; all state and counters return to reset values.

## Timing
- Cycle 0 is the edge sampling start in IDLE. Message bit i is on encoder_i in cycle 1+i, and tail bit j in cycle 1+FRAME_LEN+j.
- err_inj for word w is asserted in cycle 2+w, one cycle after encoder_i for that word, matching the encoder's registered output.
- decoder_o for message bit i is sampled in cycle 1+i+DEC_LAT. The counter update is visible the following cycle.
- done is high in cycle 2+FRAME_LEN+DEC_LAT, and bit_err_ct is final in that same cycle.
- busy is high in cycles 1..2+FRAME_LEN+DEC_LAT. IDLE is entered the next cycle, and the earliest next start is sampled there.

## Test plan
- Ideal decoder model (decoder_o = encoder_i delayed 40), err_en=0, start at cycle 0 → done pulse at cycle 106; bit_err_ct=0, inj_ct=0, frame_ct=1; encoder_i bits 0..3 match the LFSR from 16'hACE1.
- Same, but the model inverts message bit 10 → bit_err_ct=1 at done, and no other field changes.
- err_en=1, mask 2'b11 → err_inj=2'b11 in cycles 2, 18, 34, 50, 66 only; inj_ct=5. Mask 2'b00 → inj_ct=0 and err_inj stays 0.
- Pulse start at cycles 0 and 30 → only one frame; done once at 106; frame_ct=1.
- Assert rst at cycle 20, then start → all outputs 0 the cycle after rst; the new frame replays the identical encoder_i sequence from SEED, and no done pulse occurs for the aborted frame.
- start held high over three frames → consecutive done pulses 107 cycles apart; frame_ct=3; the LFSR sequence continues across frames without repeating.
